// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register bank: FSM state encoding,
// R/W bit meaning and the frame length helper.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } spi_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Total SCLK rising edges in one complete frame: R/W bit, address, data.
    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, followed by an edge
// detect flop; reports the synchronised level and single-cycle rise/fall.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Resetting to 0 means a chip select held low through reset never looks
    // like a falling edge, so a frame can only begin on a genuine ncs fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  = level & ~r_prev;
    assign fall  = ~level & r_prev;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral with a bank of control registers, fully oversampled
// in the clk domain: write commit strobe, register readback and frame errors.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_copi_lvl, w_copi_rise, w_copi_fall;
    logic w_ncs_lvl,  w_ncs_rise,  w_ncs_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin(sclk),
        .level(w_sclk_lvl), .rise(w_sclk_rise), .fall(w_sclk_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst(rst), .pin(copi),
        .level(w_copi_lvl), .rise(w_copi_rise), .fall(w_copi_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst(rst), .pin(ncs),
        .level(w_ncs_lvl), .rise(w_ncs_rise), .fall(w_ncs_fall)
    );

    logic w_unused_pins;
    assign w_unused_pins = ^{w_sclk_lvl, w_copi_rise, w_copi_fall, w_ncs_lvl};

    spi_state_t        r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rd_shift;
    logic              r_cipo_oe;
    logic              r_wr_strobe;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_frame_err;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [ADDR_W-1:0] w_addr_next;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_addr_ok;
    logic              w_commit;

    assign w_addr_next = {r_addr[ADDR_W-2:0], w_copi_lvl};
    assign w_addr_ok   = {1'b0, r_addr} < (ADDR_W+1)'(NUM_REGS);
    assign w_commit    = (r_state == ST_DONE) && w_ncs_rise
                         && (r_rw == RW_WRITE) && w_addr_ok;

    // Out-of-range read addresses match no register and return zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_addr_next == ADDR_W'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rd_shift  <= '0;
            r_cipo_oe   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            if ((r_state != ST_IDLE) && w_ncs_rise) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                r_cipo_oe <= 1'b0;
                if (r_state != ST_DONE) begin
                    r_frame_err <= 1'b1;
                end else if (r_rw == RW_WRITE) begin
                    if (w_addr_ok) begin
                        r_wr_strobe <= 1'b1;
                        r_wr_addr   <= r_addr;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ncs_fall) begin
                            r_state   <= ST_CMD;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_rw      <= w_copi_lvl;
                            r_state   <= ST_ADDR;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_ADDR: begin
                        if (w_sclk_rise) begin
                            r_addr <= w_addr_next;
                            if (r_bit_cnt == CNT_W'(ADDR_W - 1)) begin
                                r_state   <= ST_DATA;
                                r_bit_cnt <= '0;
                                if (r_rw == RW_READ) begin
                                    r_rd_shift <= w_rd_data;
                                    r_cipo_oe  <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_sclk_rise) begin
                            r_data <= {r_data[DATA_W-2:0], w_copi_lvl};
                            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                                r_state   <= ST_DONE;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else if (w_sclk_fall && r_cipo_oe && (r_bit_cnt != '0)) begin
                            // The fall before the first data rise must keep the
                            // MSB on the pin, so shifting starts after that rise.
                            r_rd_shift <= {r_rd_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                    ST_DONE: begin
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_addr == ADDR_W'(i)) begin
                    r_regs[i] <= r_data;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
            assign regs_o[gi*DATA_W +: DATA_W] = r_regs[gi];
        end
    endgenerate

    assign cipo      = r_cipo_oe & r_rd_shift[DATA_W-1];
    assign cipo_oe   = r_cipo_oe;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: drives SPI frames at clk/10 and checks the
// register bank, strobes, readback and error pulses against hand-computed values.
module tb_spi_reg_bank;
    import spi_pkg::*;

    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;
    localparam int FL       = frame_len(ADDR_W, DATA_W);
    localparam int HALF     = 5;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       sclk;
    logic                       copi;
    logic                       ncs;
    logic                       cipo;
    logic                       cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] regs_o;
    logic                       wr_strobe;
    logic [ADDR_W-1:0]          wr_addr;
    logic                       frame_err;

    int tests_run  = 0;
    int tests_fail = 0;
    int strobe_cnt = 0;
    int err_cnt    = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;

    logic [DATA_W-1:0] rdata;
    logic              oe_all;

    spi_reg_bank #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs_o(regs_o),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse; a single 1-clk pulse adds exactly one.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe) begin
                strobe_cnt   = strobe_cnt + 1;
                last_wr_addr = wr_addr;
            end
            if (frame_err) err_cnt = err_cnt + 1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends the first 1+ADDR_W+ndata bits of a frame; cipo is sampled just
    // before each data-phase rising edge, as a mode-0 controller would.
    task automatic spi_frame(input logic rw, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data, input int ndata,
                             input bit end_frame, input int gap);
        logic [FL-1:0] frame;
        frame  = {rw, addr, data};
        rdata  = '0;
        oe_all = 1'b1;
        ncs    = 1'b0;
        for (int b = FL - 1; b >= DATA_W - ndata; b--) begin
            copi = frame[b];
            wait_clk(HALF);
            if (b < DATA_W) begin
                rdata[b] = cipo;
                oe_all   = oe_all & cipo_oe;
            end
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        if (end_frame) begin
            ncs = 1'b1;
            wait_clk(gap);
        end
        $display("[TB] frame rw=%0d addr=0x%02h data=0x%02h bits=%0d -> cipo_data=0x%02h regs=0x%010h",
                 rw, addr, data, ndata, rdata, regs_o);
    endtask

    initial begin
        int strobe_base;
        rst  = 1'b1;
        ncs  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        wait_clk(5);
        check("rst_regs",      regs_o,    40'h0);
        check("rst_cipo_oe",   cipo_oe,   1'b0);
        check("rst_cipo",      cipo,      1'b0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr",   wr_addr,   7'h0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_state",     dut.r_state, ST_IDLE);
        rst = 1'b0;
        wait_clk(6);

        spi_frame(RW_WRITE, 7'h02, 8'hA5, 8, 1'b1, 10);
        check("wr2_regs",     regs_o,       40'h00_00_A5_00_00);
        check("wr2_strobes",  strobe_cnt,   1);
        check("wr2_addr",     last_wr_addr, 7'h02);
        check("wr2_addr_out", wr_addr,      7'h02);
        check("wr2_no_err",   err_cnt,      0);

        spi_frame(RW_READ, 7'h02, 8'h00, 8, 1'b1, 10);
        check("rd2_data",    rdata,      8'hA5);
        check("rd2_oe",      oe_all,     1'b1);
        check("rd2_oe_off",  cipo_oe,    1'b0);
        check("rd2_regs",    regs_o,     40'h00_00_A5_00_00);
        check("rd2_strobes", strobe_cnt, 1);

        spi_frame(RW_WRITE, 7'h05, 8'hFF, 8, 1'b1, 10);
        check("wr5_err",     err_cnt,    1);
        check("wr5_strobes", strobe_cnt, 1);
        check("wr5_regs",    regs_o,     40'h00_00_A5_00_00);

        spi_frame(RW_READ, 7'h06, 8'h00, 8, 1'b1, 10);
        check("rd6_data", rdata,   8'h00);
        check("rd6_oe",   oe_all,  1'b1);
        check("rd6_err",  err_cnt, 1);

        spi_frame(RW_WRITE, 7'h00, 8'h3C, 4, 1'b1, 10);
        check("trunc_err",     err_cnt,    2);
        check("trunc_strobes", strobe_cnt, 1);
        check("trunc_regs",    regs_o,     40'h00_00_A5_00_00);

        spi_frame(RW_WRITE, 7'h00, 8'h3C, 8, 1'b1, 10);
        check("wr0_regs",    regs_o,       40'h00_00_A5_00_3C);
        check("wr0_strobes", strobe_cnt,   2);
        check("wr0_addr",    last_wr_addr, 7'h00);

        spi_frame(RW_WRITE, 7'h01, 8'h7E, 4, 1'b0, 0);
        rst = 1'b1;
        wait_clk(3);
        check("midrst_regs",  regs_o,      40'h0);
        check("midrst_state", dut.r_state, ST_IDLE);
        check("midrst_oe",    cipo_oe,     1'b0);
        rst = 1'b0;
        wait_clk(6);
        ncs = 1'b1;
        wait_clk(10);
        check("midrst_idle",  dut.r_state, ST_IDLE);
        check("midrst_noerr", err_cnt,     2);
        spi_frame(RW_WRITE, 7'h01, 8'h7E, 8, 1'b1, 10);
        check("wr1_regs",    regs_o,     40'h00_00_00_7E_00);
        check("wr1_strobes", strobe_cnt, 3);

        strobe_base = strobe_cnt;
        for (int i = 0; i < NUM_REGS; i++) begin
            spi_frame(RW_WRITE, 7'(i), 8'(8'h11 * (i + 1)), 8, 1'b1, 4);
        end
        wait_clk(10);
        check("b2b_regs",    regs_o,                   40'h55_44_33_22_11);
        check("b2b_strobes", strobe_cnt - strobe_base, 5);
        check("b2b_addr",    last_wr_addr,             7'h04);
        check("b2b_err",     err_cnt,                  2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
